// File: rtl/pwm_multi.sv
// Multi-channel PWM generator. One shared prescaler and period counter feed
// any number of channels. Each channel keeps a write-anytime target duty and
// an active duty that is only refreshed at period boundaries, either by a
// direct copy or by a saturating soft-start ramp.
module pwm_multi #(
    parameter int WIDTH     = 4,
    parameter int CHANNELS  = 2,
    parameter int PRESCALE  = 1,
    parameter int RAMP_STEP = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*WIDTH-1:0]    duty_in,
    input  logic [CHANNELS-1:0]          duty_we,
    input  logic                         ramp_en,
    input  logic                         enable,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         period_start,
    output logic [CHANNELS-1:0]          ramping
);

    // Counter runs 0..MAX, so a period is 2^WIDTH-1 ticks and a duty of
    // 2^WIDTH-1 keeps the output high across the wrap.
    localparam logic [WIDTH-1:0] MAX = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam int               PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam int               SW  = WIDTH + 1;
    localparam logic [SW-1:0]    STEP = SW'(RAMP_STEP);

    logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             period_start_q;
    logic             tick;
    logic             boundary;

    assign tick     = enable && (pre_cnt_q == PRE_LAST);
    assign boundary = tick && (cnt_q == MAX);

    // Prescaler and period counter next state; disable parks both at zero.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        cnt_d     = cnt_q;
        if (!enable) begin
            pre_cnt_d = '0;
            cnt_d     = '0;
        end else begin
            if (pre_cnt_q == PRE_LAST) begin
                pre_cnt_d = '0;
            end else begin
                pre_cnt_d = pre_cnt_q + 1'b1;
            end
            if (tick) begin
                cnt_d = (cnt_q == MAX) ? '0 : cnt_q + 1'b1;
            end
        end
    end

    // Shared timing registers; period_start marks the first cycle at cnt=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt_q      <= '0;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            cnt_q          <= cnt_d;
            period_start_q <= boundary;
        end
    end

    assign period_start = period_start_q;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] target_q;
            logic [WIDTH-1:0] active_q, active_d;
            logic             pwm_q;
            logic [SW-1:0]    act_ext, tgt_ext, step_up, tgt_plus;

            // Widened arithmetic so ramp sums never wrap before clamping.
            assign act_ext  = {1'b0, active_q};
            assign tgt_ext  = {1'b0, target_q};
            assign step_up  = act_ext + STEP;
            assign tgt_plus = tgt_ext + STEP;

            // Active duty moves toward target only at a period boundary.
            always_comb begin
                active_d = active_q;
                if (boundary) begin
                    if (!ramp_en || (active_q == target_q)) begin
                        active_d = target_q;
                    end else if (active_q < target_q) begin
                        active_d = (step_up >= tgt_ext) ? target_q : step_up[WIDTH-1:0];
                    end else begin
                        active_d = (act_ext <= tgt_plus) ? target_q
                                                         : active_q - STEP[WIDTH-1:0];
                    end
                end
            end

            // Per-channel state: target capture, active update, output compare.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    target_q <= '0;
                    active_q <= '0;
                    pwm_q    <= 1'b0;
                end else begin
                    if (duty_we[gi]) begin
                        target_q <= duty_in[gi*WIDTH +: WIDTH];
                    end
                    active_q <= active_d;
                    pwm_q    <= enable && (cnt_q < active_q);
                end
            end

            assign pwm_out[gi] = pwm_q;
            assign ramping[gi] = (active_q != target_q);
        end
    endgenerate

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi. Three instances share one stimulus stream:
// the default build, a RAMP_STEP=2 build and a PRESCALE=4 build.
module tb_pwm_multi;

    logic       clk;
    logic       rst;
    logic [7:0] duty_in;
    logic [1:0] duty_we;
    logic       ramp_en;
    logic       enable;

    logic [1:0] pwm_m, ramp_m, pwm_s, ramp_s, pwm_p, ramp_p;
    logic       ps_m, ps_s, ps_p;

    int total = 0;
    int bad   = 0;

    int h0, h1, hs, hp, nps, npp;
    logic [1:0] r_first;
    int n;

    pwm_multi #(.WIDTH(4), .CHANNELS(2), .PRESCALE(1), .RAMP_STEP(1)) u_dut (
        .clk(clk), .rst(rst), .duty_in(duty_in), .duty_we(duty_we),
        .ramp_en(ramp_en), .enable(enable),
        .pwm_out(pwm_m), .period_start(ps_m), .ramping(ramp_m)
    );

    pwm_multi #(.WIDTH(4), .CHANNELS(2), .PRESCALE(1), .RAMP_STEP(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .duty_in(duty_in), .duty_we(duty_we),
        .ramp_en(ramp_en), .enable(enable),
        .pwm_out(pwm_s), .period_start(ps_s), .ramping(ramp_s)
    );

    pwm_multi #(.WIDTH(4), .CHANNELS(2), .PRESCALE(4), .RAMP_STEP(1)) u_dut_p4 (
        .clk(clk), .rst(rst), .duty_in(duty_in), .duty_we(duty_we),
        .ramp_en(ramp_en), .enable(enable),
        .pwm_out(pwm_p), .period_start(ps_p), .ramping(ramp_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: got=%0d", tag, got);
        end
    endtask

    // Runs len clocks from the current negedge, optionally writing duty at
    // step wr_at, and tallies high samples and period_start pulses.
    task automatic run_period(input int len, input int wr_at,
                              input logic [7:0] wd, input logic [1:0] wm);
        h0 = 0; h1 = 0; hs = 0; hp = 0; nps = 0; npp = 0;
        r_first = 2'b00;
        for (int i = 0; i < len; i++) begin
            if (i == wr_at) begin
                duty_in = wd;
                duty_we = wm;
            end else begin
                duty_we = 2'b00;
            end
            @(negedge clk);
            h0  += int'(pwm_m[0]);
            h1  += int'(pwm_m[1]);
            hs  += int'(pwm_s[0]);
            hp  += int'(pwm_p[0]);
            nps += int'(ps_m);
            npp += int'(ps_p);
            if (i == 0) r_first = ramp_m;
        end
        duty_we = 2'b00;
    endtask

    // Waits (bounded) for period_start of the default or prescaled instance.
    task automatic wait_ps(input bit use_p4, output int cnt);
        bit seen;
        seen = 1'b0;
        cnt  = 0;
        while (!seen && cnt < 300) begin
            @(negedge clk);
            cnt++;
            seen = use_p4 ? ps_p : ps_m;
        end
        chk("ps_seen", int'(seen), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int exp_up_m[4]  = '{1, 2, 3, 4};
    int exp_up_s[4]  = '{2, 4, 4, 4};
    int exp_up_r[4]  = '{1, 1, 1, 0};
    int exp_dn_m[3]  = '{3, 2, 1};
    int exp_dn_s[3]  = '{2, 1, 1};

    initial begin
        rst = 1'b0; duty_in = 8'h00; duty_we = 2'b00; ramp_en = 1'b0; enable = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_pwm", int'(pwm_m), 0);
        chk("rst_ps", int'(ps_m), 0);
        chk("rst_ramping", int'(ramp_m), 0);

        // Extremes: ch0 duty 0, ch1 duty 15
        rst = 1'b1; enable = 1'b1; duty_in = 8'hF0; duty_we = 2'b11;
        @(negedge clk);
        duty_we = 2'b00;
        wait_ps(1'b0, n);
        chk("first_ps_delay", n, 14);
        run_period(45, -1, 8'h00, 2'b00);
        chk("ext_ch0_high", h0, 0);
        chk("ext_ch1_high", h1, 45);
        chk("ext_ps_count", nps, 3);
        chk("ext_ramping", int'(r_first), 0);

        // Shadow update on ch0
        run_period(15, 0, 8'hF8, 2'b01);
        chk("shadow_pre", h0, 0);
        run_period(15, 5, 8'hF3, 2'b01);
        chk("shadow_8_mid_write", h0, 8);
        run_period(15, -1, 8'h00, 2'b00);
        chk("shadow_3", h0, 3);
        run_period(15, 14, 8'hFC, 2'b01);
        chk("coincident_cur", h0, 3);
        run_period(15, -1, 8'h00, 2'b00);
        chk("coincident_next", h0, 3);
        run_period(15, -1, 8'h00, 2'b00);
        chk("coincident_applied", h0, 12);
        chk("coincident_ps", nps, 1);

        // Async reset while running
        duty_in = 8'h5C; duty_we = 2'b10;
        @(negedge clk);
        duty_we = 2'b00;
        chk("pre_rst_pwm", int'(pwm_m), 3);
        chk("pre_rst_ramping", int'(ramp_m), 2);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_pwm", int'(pwm_m), 0);
        chk("async_rst_ps", int'(ps_m), 0);
        chk("async_rst_ramping", int'(ramp_m), 0);
        @(negedge clk);
        rst = 1'b1;
        wait_ps(1'b0, n);
        chk("restart_ps_delay", n, 15);

        // Soft start to 4 (step 1 and step 2 instances)
        ramp_en = 1'b1;
        run_period(15, 0, 8'h04, 2'b01);
        chk("soft_p0_h0", h0, 0);
        chk("soft_p0_ramping", int'(r_first), 1);
        for (int p = 0; p < 4; p++) begin
            run_period(15, -1, 8'h00, 2'b00);
            chk($sformatf("soft_up_h0_%0d", p), h0, exp_up_m[p]);
            chk($sformatf("soft_up_s2_%0d", p), hs, exp_up_s[p]);
            chk($sformatf("soft_up_ramping_%0d", p), int'(r_first), exp_up_r[p]);
        end

        // Ramp down to 1
        run_period(15, 0, 8'h01, 2'b01);
        chk("soft_dn_start_h0", h0, 4);
        chk("soft_dn_start_s2", hs, 4);
        for (int p = 0; p < 3; p++) begin
            run_period(15, -1, 8'h00, 2'b00);
            chk($sformatf("soft_dn_h0_%0d", p), h0, exp_dn_m[p]);
            chk($sformatf("soft_dn_s2_%0d", p), hs, exp_dn_s[p]);
        end

        // Enable drop at cnt=6 with duty 10
        ramp_en = 1'b0;
        run_period(15, 0, 8'h0A, 2'b01);
        chk("drop_prep_h0", h0, 1);
        run_period(6, -1, 8'h00, 2'b00);
        chk("drop_before_h0", h0, 6);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_pwm", int'(pwm_m), 0);
        duty_in = 8'h7A; duty_we = 2'b10;
        @(negedge clk);
        duty_we = 2'b00;
        chk("drop_target_write", int'(ramp_m), 2);
        run_period(10, -1, 8'h00, 2'b00);
        chk("drop_idle_h0", h0, 0);
        chk("drop_idle_ps", nps, 0);
        enable = 1'b1;
        run_period(15, -1, 8'h00, 2'b00);
        chk("reen_h0", h0, 10);
        chk("reen_h1", h1, 0);
        chk("reen_ps_count", nps, 1);
        chk("reen_ps_at_end", int'(ps_m), 1);
        run_period(15, -1, 8'h00, 2'b00);
        chk("reen_next_h0", h0, 10);
        chk("reen_next_h1", h1, 7);

        // Prescale 4 with duty 5
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; duty_in = 8'h05; duty_we = 2'b01;
        @(negedge clk);
        duty_we = 2'b00;
        wait_ps(1'b1, n);
        chk("p4_first_ps_delay", n, 59);
        run_period(120, -1, 8'h00, 2'b00);
        chk("p4_high", hp, 40);
        chk("p4_ps_count", npp, 2);
        chk("p4_ps_at_end", int'(ps_p), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
